dsi_lanes_ctrl: RTL
===================

Name: dsi_lanes_ctrl

Overview:
- Sequences one HS clock lane and LANES HS data lanes (dsi_hs_lane instances, clock lane with MODE=1) for a single high-speed burst.
- Takes a byte-striped packet stream from the packet assembler and starts the clock lane first, then the data lanes.
- Distributes one byte per lane per clk_sys cycle, then closes the data lanes before the clock lane, honouring clk-pre/clk-post spacing.
- Sits between the DSI packet assembler and the PHY lane instances, all in the clk_sys domain.

Parameters:
- LANES, 4, number of data lanes (1..4).
- T_CLK_PRE, 8, clk_sys cycles between clock lane active and data lane start_rqst.
- T_CLK_POST, 8, clk_sys cycles between last data fin_ack and clock lane fin_rqst.
- CW, 8, width of the timing counters.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- in_data  in  8*LANES  striped bytes; lane i takes [8i+7:8i]
- in_valid  in  1  in_data valid
- in_last  in  1  final beat of burst
- in_ready  out  1  beat accepted when in_valid&in_ready
- clk_start_rqst  out  1  to clock lane start_rqst
- clk_fin_rqst  out  1  to clock lane fin_rqst
- clk_active  in  1  clock lane active
- clk_fin_ack  in  1  clock lane fin_ack (1-cycle pulse)
- lane_start_rqst  out  LANES  per data lane start_rqst
- lane_fin_rqst  out  LANES  per data lane fin_rqst
- lane_data  out  8*LANES  per data lane inp_data
- lane_data_rqst  in  LANES  per lane data_rqst
- lane_fin_ack  in  LANES  per lane fin_ack (1-cycle pulses, may be skewed)
- busy  out  1  state != IDLE
- underflow  out  1  1-cycle pulse, see below

Behaviour:
- Reset: state IDLE; all outputs 0, including lane_data = 0, in_ready, busy, underflow.
- IDLE: in_valid=1 -> CLK_START. The beat is not consumed.
- CLK_START: clk_start_rqst=1 for exactly the first cycle in the state. Wait for clk_active=1, then load the counter with T_CLK_PRE. At counter==0 -> DATA_START.
- DATA_START: lane_start_rqst = all ones for one cycle -> DATA_TX.
- DATA_TX:
  - in_ready = &lane_data_rqst.
  - On accept: lane_data <= in_data (registered, latency 1). Otherwise lane_data <= 0.
  - Accept with in_last=1 sets last_sent. The next cycle goes to DATA_FIN, so the last bytes are on lane_data for exactly one cycle.
  - Underflow: in_ready=1, in_valid=0 and last_sent=0 -> underflow pulses 1 cycle, lane_data <= 0, state stays in DATA_TX.
- DATA_FIN:
  - lane_fin_rqst = all ones while in the state.
  - Per-lane sticky done bits set on lane_fin_ack[i].
  - Once all LANES bits are set: clear the bits, drop fin_rqst, load the counter with T_CLK_POST -> CLK_POST.
- CLK_POST: count down; at 0 -> CLK_FIN.
- CLK_FIN: clk_fin_rqst=1 until clk_fin_ack -> IDLE.
- Counters decrement to 0 and saturate; a parameter value of 0 means a 1-cycle pass.
- fin_ack skew: acks arriving on different cycles are all collected. An ack on the same cycle as entry to DATA_FIN is counted.
- in_valid during CLK_START, DATA_START, DATA_FIN, CLK_POST, CLK_FIN: ignored, in_ready=0. A new burst starts only from IDLE.
- Reset mid-burst: immediate return to IDLE with all requests low. Lanes reset on the same rst_n.
- Unused upper lanes do not exist; widths scale with LANES.

Decomposition:
- Package dsi_pkg:
  - state enum: IDLE, CLK_START, CLK_PRE, DATA_START, DATA_TX, DATA_FIN, CLK_POST, CLK_FIN.
  - default timing constants T_CLK_PRE_DEF, T_CLK_POST_DEF.
- One sub-module, dsi_timer: loadable down-counter of width CW with a zero flag. Instantiated once and shared by CLK_PRE and CLK_POST.

Test Plan:
- LANES=4, burst of 3 beats (0x03020100, 0x07060504, 0x0B0A0908 last), lanes model data_rqst 1 cycle after start -> each beat's bytes on lane_data one cycle after accept. Clock start precedes lane start by ≥ T_CLK_PRE+1 cycles. fin_rqst follows the last beat by 1 cycle.
- Single-beat burst with in_last=1 -> one accept, DATA_FIN directly after; clk_fin_rqst asserted only T_CLK_POST+1 cycles after the last fin_ack.
- Skewed lane_fin_ack (lanes 0..3 ack at +0,+2,+5,+9 cycles) -> CLK_POST entered only after the lane 3 ack; no early clk_fin_rqst.
- Drop in_valid for 2 cycles mid-burst -> underflow pulses twice, lane_data = 0x00 on those cycles, burst completes normally.
- Assert rst_n=0 during DATA_TX -> all outputs 0 asynchronously, busy=0; next in_valid restarts the full sequence from CLK_START.
- T_CLK_PRE=0, T_CLK_POST=0 -> each wait lasts 1 cycle, no hang, back to IDLE after clk_fin_ack.

Source files
------------

// File: rtl/dsi_lanes_ctrl_pkg.sv
// Shared types and default timing for the DSI lane sequencer.
package dsi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLK_START,
    CLK_PRE,
    DATA_START,
    DATA_TX,
    DATA_FIN,
    CLK_POST,
    CLK_FIN
  } dsi_state_e;

  localparam int T_CLK_PRE_DEF  = 8;
  localparam int T_CLK_POST_DEF = 8;

endpackage

// File: rtl/dsi_lanes_ctrl_if.sv
// Byte-striped beat stream from the packet assembler into the lane sequencer.
interface dsi_lanes_ctrl_if #(
  parameter int LANES = 4
);
  logic [8*LANES-1:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;

  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave  (input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/dsi_lanes_ctrl_timer.sv
// Loadable saturating down-counter; shared by the clk-pre and clk-post waits.
module dsi_timer #(
  parameter int CW = 8
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);
endmodule

// File: rtl/dsi_lanes_ctrl.sv
// Sequences one HS clock lane and LANES data lanes through a single burst:
// clock up, data lanes up, stream beats, data lanes down, clock down.
module dsi_lanes_ctrl
  import dsi_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int T_CLK_PRE  = T_CLK_PRE_DEF,
  parameter int T_CLK_POST = T_CLK_POST_DEF,
  parameter int CW         = 8
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  dsi_lanes_ctrl_if.slave    in_s,
  output logic               clk_start_rqst,
  output logic               clk_fin_rqst,
  input  logic               clk_active,
  input  logic               clk_fin_ack,
  output logic [LANES-1:0]   lane_start_rqst,
  output logic [LANES-1:0]   lane_fin_rqst,
  output logic [8*LANES-1:0] lane_data,
  input  logic [LANES-1:0]   lane_data_rqst,
  input  logic [LANES-1:0]   lane_fin_ack,
  output logic               busy,
  output logic               underflow
);
  dsi_state_e         state_reg, state_next;
  logic               start_sent_reg;
  logic               last_sent_reg;
  logic [LANES-1:0]   done_reg;
  logic [8*LANES-1:0] lane_data_reg;
  logic               tmr_load, tmr_zero;
  logic [CW-1:0]      tmr_val;
  logic               ready_int, accept, all_done;

  assign ready_int   = (state_reg == DATA_TX) && (&lane_data_rqst);
  assign in_s.in_ready = ready_int;
  assign accept      = ready_int && in_s.in_valid;
  // An ack landing in the same cycle as the final missing bit still completes the set.
  assign all_done    = &(done_reg | lane_fin_ack);
  assign busy        = (state_reg != IDLE);
  assign lane_data   = lane_data_reg;

  dsi_timer #(.CW(CW)) u_timer (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next      = state_reg;
    clk_start_rqst  = 1'b0;
    clk_fin_rqst    = 1'b0;
    lane_start_rqst = '0;
    lane_fin_rqst   = '0;
    underflow       = 1'b0;
    tmr_load        = 1'b0;
    tmr_val         = '0;
    case (state_reg)
      IDLE: if (in_s.in_valid) state_next = CLK_START;
      CLK_START: begin
        clk_start_rqst = !start_sent_reg;
        if (clk_active) begin
          tmr_load   = 1'b1;
          tmr_val    = CW'(T_CLK_PRE);
          state_next = CLK_PRE;
        end
      end
      CLK_PRE: if (tmr_zero) state_next = DATA_START;
      DATA_START: begin
        lane_start_rqst = '1;
        state_next      = DATA_TX;
      end
      DATA_TX: begin
        underflow = ready_int && !in_s.in_valid && !last_sent_reg;
        if (accept && in_s.in_last) state_next = DATA_FIN;
      end
      DATA_FIN: begin
        lane_fin_rqst = '1;
        if (all_done) begin
          tmr_load   = 1'b1;
          tmr_val    = CW'(T_CLK_POST);
          state_next = CLK_POST;
        end
      end
      CLK_POST: if (tmr_zero) state_next = CLK_FIN;
      CLK_FIN: begin
        clk_fin_rqst = 1'b1;
        if (clk_fin_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      start_sent_reg <= 1'b0;
      last_sent_reg  <= 1'b0;
      lane_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      start_sent_reg <= (state_reg == CLK_START);
      if (state_reg == IDLE) begin
        last_sent_reg <= 1'b0;
      end else if (accept && in_s.in_last) begin
        last_sent_reg <= 1'b1;
      end
      lane_data_reg  <= accept ? in_s.in_data : '0;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_done
    always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
        done_reg[gi] <= 1'b0;
      end else if (state_reg == DATA_FIN && !all_done) begin
        done_reg[gi] <= done_reg[gi] | lane_fin_ack[gi];
      end else begin
        done_reg[gi] <= 1'b0;
      end
    end
  end
endmodule
